// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

    localparam int         PAT_W_DEF        = 4;
    localparam int         CNT_W_DEF        = 8;
    localparam logic [3:0] DEFAULT_PAT_1010 = 4'b1010;

    // Width needed for a counter that saturates at pat_w (inclusive).
    function automatic int FILL_W(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear coinciding with an increment yields 1.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear keeps a coincident event.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pattern_seq_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern, selectable
// overlapping/non-overlapping detection, registered match pulse and a
// saturating match counter.
module pattern_seq_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = PAT_W_DEF,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(DEFAULT_PAT_1010)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pat_o
);

    localparam int FW = FILL_W(PAT_W);

    // Only the newest PAT_W-1 history bits are ever compared: the oldest bit
    // of a PAT_W window is always shifted out by the incoming bit.
    logic [PAT_W-1:0] pat;
    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] window;
    logic             hit;

    // Candidate window including the bit presented this cycle, and the hit test.
    always_comb begin
        window = {hist, in};
        hit    = in_valid && !pat_load
                 && (fill >= FW'(PAT_W - 1))
                 && (window == pat);
    end

    // Pattern register, shift history, fill level and registered match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat   <= DEFAULT_PAT;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (pat_load) begin
            pat   <= pat_in;
            fill  <= '0;
            match <= 1'b0;
        end else if (in_valid) begin
            hist  <= window[PAT_W-2:0];
            match <= hit;
            if (hit && !overlap) begin
                fill <= '0;
            end else if (fill != FW'(PAT_W)) begin
                fill <= fill + FW'(1);
            end
        end else begin
            match <= 1'b0;
        end
    end

    assign pat_o = pat;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Self-checking bench for pattern_seq_detector: expected match pulses are
// queued as each bit is driven and popped when the registered output appears.
module tb_pattern_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in = 1'b0;
    logic       overlap = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       cnt_clr = 1'b0;

    logic       match;
    logic [7:0] match_cnt;
    logic [3:0] pat_o;
    logic       match2;
    logic [1:0] match_cnt2;
    logic [3:0] pat_o2;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    pattern_seq_detector #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .match(match), .match_cnt(match_cnt), .pat_o(pat_o)
    );

    pattern_seq_detector #(.PAT_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .match(match2), .match_cnt(match_cnt2), .pat_o(pat_o2)
    );

    task automatic drive(input logic v, input logic b);
        in_valid = v;
        in       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic e;
        do_reset();
        n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL reset_match: got %b want 0", match); end
        n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
        n_cmp++; if (pat_o !== 4'b1010) begin n_err++; $display("FAIL reset_pat: got %b want 1010", pat_o); end
        n_cmp++; if (pat_o2 !== 4'b1010) begin n_err++; $display("FAIL reset_pat2: got %b want 1010", pat_o2); end
        exp_q.push_back(1'b0);
        drive(1'b0, 1'b1);
        e = exp_q.pop_front();
        n_cmp++; if (match !== e) begin n_err++; $display("FAIL reset_idle: got %b want %b", match, e); end
    endtask

    task automatic test_overlap();
        logic [5:0] bits = 6'b101010;
        logic [5:0] exp  = 6'b000101;
        logic e;
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exp[5-i]);
            drive(1'b1, bits[5-i]);
            e = exp_q.pop_front();
            n_cmp++; if (match !== e) begin n_err++; $display("FAIL overlap_bit%0d: got %b want %b", i+1, match, e); end
        end
        in_valid = 1'b0;
        n_cmp++; if (match_cnt !== 8'd2) begin n_err++; $display("FAIL overlap_cnt: got %0d want 2", match_cnt); end
    endtask

    task automatic test_non_overlap();
        logic [5:0] bits6 = 6'b101010;
        logic [5:0] exp6  = 6'b000100;
        logic [7:0] bits8 = 8'b10101010;
        logic [7:0] exp8  = 8'b00010001;
        logic e;
        do_reset();
        overlap = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exp6[5-i]);
            drive(1'b1, bits6[5-i]);
            e = exp_q.pop_front();
            n_cmp++; if (match !== e) begin n_err++; $display("FAIL nonov6_bit%0d: got %b want %b", i+1, match, e); end
        end
        n_cmp++; if (match_cnt !== 8'd1) begin n_err++; $display("FAIL nonov6_cnt: got %0d want 1", match_cnt); end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(exp8[7-i]);
            drive(1'b1, bits8[7-i]);
            e = exp_q.pop_front();
            n_cmp++; if (match !== e) begin n_err++; $display("FAIL nonov8_bit%0d: got %b want %b", i+1, match, e); end
        end
        in_valid = 1'b0;
        n_cmp++; if (match_cnt !== 8'd2) begin n_err++; $display("FAIL nonov8_cnt: got %0d want 2", match_cnt); end
    endtask

    task automatic test_valid_gaps();
        logic [6:0] v   = 7'b1100011;
        logic [6:0] b   = 7'b1010110;
        logic [6:0] exp = 7'b0000001;
        logic e;
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(exp[6-i]);
            drive(v[6-i], b[6-i]);
            e = exp_q.pop_front();
            n_cmp++; if (match !== e) begin n_err++; $display("FAIL gaps_cyc%0d: got %b want %b", i+1, match, e); end
        end
        in_valid = 1'b0;
        n_cmp++; if (match_cnt !== 8'd1) begin n_err++; $display("FAIL gaps_cnt: got %0d want 1", match_cnt); end
    endtask

    task automatic test_pat_load();
        logic [6:0] bits = 7'b0110110;
        logic [6:0] exp  = 7'b0001001;
        logic e;
        do_reset();
        overlap  = 1'b1;
        pat_load = 1'b1;
        pat_in   = 4'b0110;
        exp_q.push_back(1'b0);
        drive(1'b1, 1'b0);
        pat_load = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (match !== e) begin n_err++; $display("FAIL load_match: got %b want %b", match, e); end
        n_cmp++; if (pat_o !== 4'b0110) begin n_err++; $display("FAIL load_pat: got %b want 0110", pat_o); end
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(exp[6-i]);
            drive(1'b1, bits[6-i]);
            e = exp_q.pop_front();
            n_cmp++; if (match !== e) begin n_err++; $display("FAIL load_bit%0d: got %b want %b", i+1, match, e); end
        end
        in_valid = 1'b0;
        n_cmp++; if (match_cnt !== 8'd2) begin n_err++; $display("FAIL load_cnt: got %0d want 2", match_cnt); end
    endtask

    task automatic test_saturate_and_clear();
        logic [11:0] bits = 12'b101010101010;
        logic [11:0] exp  = 12'b000101010101;
        logic e;
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(exp[11-i]);
            drive(1'b1, bits[11-i]);
            e = exp_q.pop_front();
            n_cmp++; if (match2 !== e) begin n_err++; $display("FAIL sat_bit%0d: got %b want %b", i+1, match2, e); end
        end
        n_cmp++; if (match_cnt2 !== 2'd3) begin n_err++; $display("FAIL sat_cnt2: got %0d want 3", match_cnt2); end
        n_cmp++; if (match_cnt !== 8'd5) begin n_err++; $display("FAIL sat_cnt8: got %0d want 5", match_cnt); end
        drive(1'b1, 1'b1);
        cnt_clr = 1'b1;
        drive(1'b1, 1'b0);
        cnt_clr = 1'b0;
        n_cmp++; if (match !== 1'b1) begin n_err++; $display("FAIL clrhit_match: got %b want 1", match); end
        n_cmp++; if (match_cnt !== 8'd1) begin n_err++; $display("FAIL clrhit_cnt8: got %0d want 1", match_cnt); end
        n_cmp++; if (match_cnt2 !== 2'd1) begin n_err++; $display("FAIL clrhit_cnt2: got %0d want 1", match_cnt2); end
        cnt_clr = 1'b1;
        drive(1'b0, 1'b0);
        cnt_clr = 1'b0;
        n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL clr_cnt8: got %0d want 0", match_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] bits = 4'b1010;
        logic [3:0] exp  = 4'b0001;
        logic e;
        do_reset();
        overlap = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        rst = 1'b1; pat_load = 1'b1; pat_in = 4'b0001;
        drive(1'b1, 1'b0);
        rst = 1'b0; pat_load = 1'b0;
        n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL rstmid_match: got %b want 0", match); end
        n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d want 0", match_cnt); end
        n_cmp++; if (pat_o !== 4'b1010) begin n_err++; $display("FAIL rstmid_pat: got %b want 1010", pat_o); end
        exp_q.push_back(1'b0);
        drive(1'b1, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (match !== e) begin n_err++; $display("FAIL rstmid_straddle: got %b want %b", match, e); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp[3-i]);
            drive(1'b1, bits[3-i]);
            e = exp_q.pop_front();
            n_cmp++; if (match !== e) begin n_err++; $display("FAIL rstmid_bit%0d: got %b want %b", i+1, match, e); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_valid_gaps();
        test_pat_load();
        test_saturate_and_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pattern_seq_detector.md
Name: pattern_seq_detector

Overview:
- Parametrised serial bit-pattern detector, successor to the fixed 4-bit 1010 Moore detector.
- Pattern width is a parameter. The pattern is runtime-loadable.
- Overlapping or non-overlapping detection is selectable at run time.
- Input is qualified by a valid strobe. A registered one-cycle match pulse and a saturating match counter are provided.
- Sits on serial bit streams in front of framing/sync logic.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of match counter.
- DEFAULT_PAT, 4'b1010 (PAT_W bits), pattern loaded at reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  qualifies `in`; when low, no state advances.
- in  in  1  serial data bit, MSB of pattern arrives first.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  in  1  load pat_in as the new pattern.
- pat_in  in  PAT_W  new pattern value.
- cnt_clr  in  1  clear match counter.
- match  out  1  one-cycle pulse, registered.
- match_cnt  out  CNT_W  saturating count of matches.
- pat_o  out  PAT_W  currently active pattern.

Behaviour:
- Reset (rst=1 at clock edge):
  - pat <= DEFAULT_PAT.
  - hist <= 0, fill <= 0.
  - match <= 0, match_cnt <= 0.
  - Dominates all other inputs.
- hist is a PAT_W-bit shift register. fill counts valid bits held and saturates at PAT_W; its width is clog2(PAT_W+1).
- On in_valid=1:
  - hist <= {hist[PAT_W-2:0], in}.
  - fill <= min(fill+1, PAT_W).
- hit (combinational) = in_valid & (fill >= PAT_W-1) & ({hist[PAT_W-2:0], in} == pat).
- match <= hit. Latency is one cycle: match is high in the cycle after the clock edge that sampled the final pattern bit, for exactly one cycle. No combinational path from `in` to `match`.
- Overlap mode (overlap=1): history is retained after a hit, so a suffix of one match can start the next.
- Non-overlap mode (overlap=0): on a hit, fill <= 0. The next match needs PAT_W fresh valid bits.
- overlap is sampled every cycle. Changing it never clears history and applies to the next hit.
- in_valid=0: hist, fill and pat hold; match <= 0. Gaps of any length between valid bits are transparent.
- pat_load=1:
  - pat <= pat_in, fill <= 0, match <= 0.
  - The `in` bit on that cycle is discarded.
  - match_cnt is unaffected.
  - Priority: rst > pat_load > in_valid.
- match_cnt:
  - Increments on hit.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 with no hit: match_cnt <= 0.
  - cnt_clr=1 with a simultaneous hit: match_cnt <= 1, so no event is lost.
- pat_o = pat (register output).
- Reset mid-stream discards partial history. A pattern straddling reset never matches.

Decomposition:
- Shared package `seq_det_pkg`:
  - DEFAULT_PAT_1010 constant.
  - PAT_W/CNT_W default constants.
  - FILL_W function (clog2(PAT_W+1)).
- One natural sub-module, `sat_counter`:
  - Parameter CNT_W.
  - Inputs: inc, clr.
  - Saturating, with clr+inc giving 1.
  - Instanced for match_cnt.

Test Plan:
- Overlap, default 1010: valid bits 1,0,1,0,1,0 → match pulses after bits 4 and 6; match_cnt=2.
- Non-overlap, same 1,0,1,0,1,0 → single pulse after bit 4; match_cnt=1. Stream 10101010 → pulses after bits 4 and 8; count 2.
- Valid gaps: 1,0,(3 idle cycles, in toggling),1,0 → one pulse after the last valid bit. No pulse during idle.
- pat_load=1 with pat_in=0110, then overlap stream 0,1,1,0,1,1,0 → pat_o=0110; pulses after bits 4 and 7.
- CNT_W=2, 5 overlap matches of 1010 → match_cnt sticks at 3. cnt_clr coincident with a hit → match_cnt=1.
- Bits 1,0,1, then rst for one cycle, then 0 → no match; all outputs 0 and pat_o=1010 after reset.
